rx_frame_ctrl: RTL and testbench
================================

Name: rx_frame_ctrl

Overview:
- Frame-level sequencer for the OFDM receive chain: correlator/frame sync, CP removal, FFT, demapper, equalizer, soft demapper.
- Acquires sync, tracks symbol timing and indexes symbols within a frame.
- Latches the modulation, spreading and bandwidth configuration at frame boundaries only.
- Issues a datapath flush reset when sync is lost or symbols stop arriving. Sits between the control registers and the RX datapath in the clk_low_data domain.

Parameters:
- pSYM_NUM, 50, OFDM symbols per frame (symbol index wraps after pSYM_NUM-1).
- pSYM_LEN, 1056, nominal clocks per symbol (1024 FFT + 32 CP).
- pWDOG_MUL, 2, watchdog timeout in symbols; limit = pSYM_LEN*pWDOG_MUL clocks.
- pRST_CYC, 16, length of a datapath reset pulse in clocks.

Ports:
- clk  in  1  clk_low_data domain clock.
- rst  in  1  synchronous, active-high reset.
- found_sync  in  1  level from sync filter; 1 = preamble lock held.
- isym_sop  in  1  one-cycle pulse at start of each time-aligned symbol (frame sync output).
- index_M  in  3  requested modulation index.
- index_SS  in  4  requested spreading index.
- index_BW  in  3  requested bandwidth index.
- cfg_upd  in  1  pulse: request to apply index_M/SS/BW.
- dp_rst  out  1  active-high reset to the RX datapath.
- osof  out  1  pulse at symbol 0 of each frame.
- sym_idx  out  7  current symbol index within the frame.
- oindex_M  out  3  applied modulation index.
- oindex_SS  out  4  applied spreading index.
- oindex_BW  out  3  applied bandwidth index.
- locked  out  1  high in TRACK.
- sync_lost  out  1  one-cycle pulse on TRACK->FLUSH.
- frame_cnt  out  16  frames received (optional feature).
- lost_cnt  out  8  sync losses (optional feature).

Behaviour:
- Reset values:
  - State = RST; dp_rst=1; osof=0; sym_idx=0; locked=0; sync_lost=0.
  - oindex_M/SS/BW = 0; pending flag = 0; counters = 0.
- States:
  - RST: dp_rst=1 for pRST_CYC clocks (counted from the cycle after rst deasserts), then ACQ.
  - ACQ: dp_rst=0. On a cycle with found_sync=1 and isym_sop=1:
    - load pending config into oindex_* if a request is pending, otherwise keep current values;
    - sym_idx=0; osof=1 registered on the next cycle; go TRACK.
    - isym_sop with found_sync=0 is ignored.
  - TRACK: locked=1.
    - Each isym_sop: sym_idx = (sym_idx==pSYM_NUM-1) ? 0 : sym_idx+1; watchdog cleared.
    - On wrap to 0: osof pulses; pending config is applied to oindex_* in the same cycle; pending cleared.
  - FLUSH: dp_rst=1 for pRST_CYC clocks; sym_idx=0; locked=0; then ACQ.
- cfg_upd, any state: captures index_M/SS/BW into a shadow register and sets pending. The last request wins.
- Watchdog: counts clocks in TRACK since the last isym_sop, saturating. When count == pSYM_LEN*pWDOG_MUL -> FLUSH, sync_lost=1.
- found_sync=0 in TRACK -> FLUSH next cycle, sync_lost=1.
- Latency: osof and the applied config appear 1 clock after the qualifying isym_sop. dp_rst is a registered output.
- Simultaneous events:
  - isym_sop and watchdog expiry in the same cycle: isym_sop wins, no FLUSH.
  - found_sync fall and isym_sop in the same cycle: FLUSH wins, sym_idx not advanced.
  - cfg_upd and frame wrap in the same cycle: the new cfg_upd values are applied directly.
- Reset mid-operation: rst in any state returns to RST with all reset values. Pending config is discarded.

Optional Feature:
- Macro RX_CTRL_STATS_EN.
- Defined:
  - frame_cnt increments (wrapping) on every osof.
  - lost_cnt increments on every sync_lost, saturating at 255.
  - Both are cleared only by rst.
- Undefined: frame_cnt and lost_cnt are constant 0; no counter logic is synthesized.

Test Plan:
- Reset, then found_sync=1 and isym_sop every 1056 clocks:
  - dp_rst high for 16 clocks after reset release, then low;
  - locked=1 after the first sop;
  - sym_idx steps 0..49 then wraps to 0, with osof on each wrap.
- cfg_upd M=4,SS=2,BW=1 at symbol 10 of a frame: oindex_* unchanged until the wrap to symbol 0, then 4/2/1 one clock after that sop.
- Stop isym_sop in TRACK: sync_lost pulse exactly 2112 clocks after the last sop; dp_rst high 16 clocks; state returns to ACQ; with RX_CTRL_STATS_EN, lost_cnt=1.
- Drop found_sync in the same cycle as an isym_sop at sym_idx=5: FLUSH entered, sym_idx=0, no advance to 6, sync_lost=1.
- isym_sop arriving exactly on the watchdog-limit cycle: no FLUSH, watchdog restarts.
- Assert rst mid-frame with a pending cfg_upd: all outputs at reset values; after re-acquisition, oindex_* = 0.

Source files
------------

// File: rtl/rx_frame_ctrl.sv
// rx_frame_ctrl: OFDM receive frame sequencer: sync acquisition, symbol indexing, frame-aligned config apply, flush on loss.
// Optional RX_CTRL_STATS_EN adds frame_cnt/lost_cnt statistics counters.
module rx_frame_ctrl #(
  parameter int pSYM_NUM  = 50,
  parameter int pSYM_LEN  = 1056,
  parameter int pWDOG_MUL = 2,
  parameter int pRST_CYC  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        found_sync,
  input  logic        isym_sop,
  input  logic [2:0]  index_M,
  input  logic [3:0]  index_SS,
  input  logic [2:0]  index_BW,
  input  logic        cfg_upd,
  output logic        dp_rst,
  output logic        osof,
  output logic [6:0]  sym_idx,
  output logic [2:0]  oindex_M,
  output logic [3:0]  oindex_SS,
  output logic [2:0]  oindex_BW,
  output logic        locked,
  output logic        sync_lost,
  output logic [15:0] frame_cnt,
  output logic [7:0]  lost_cnt
);
  localparam int LIMIT = pSYM_LEN * pWDOG_MUL;
  localparam int WW = $clog2(LIMIT + 1);
  localparam int CW = (pRST_CYC > 1) ? $clog2(pRST_CYC) : 1;
  localparam logic [WW-1:0] WDOG_LAST = WW'(LIMIT - 1);
  localparam logic [WW-1:0] WDOG_SAT = WW'(LIMIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(pRST_CYC - 1);
  localparam logic [6:0] IDX_LAST = 7'(pSYM_NUM - 1);

  typedef enum logic [1:0] {RST, ACQ, TRACK, FLUSH} state_t;

  state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [WW-1:0] r_wdog;
  logic [6:0] r_sym_idx;
  logic [9:0] r_cfg, r_shadow;
  logic r_pend, r_osof, r_sync_lost, r_dp_rst;
  logic w_lose, w_apply, w_wrap, w_in_rst;

  always_comb begin
    w_next = r_state;
    w_lose = 1'b0;
    w_apply = 1'b0;
    w_wrap = 1'b0;
    case (r_state)
      RST, FLUSH: w_next = (r_cnt == CNT_LAST) ? ACQ : r_state;
      ACQ: begin
        w_apply = found_sync && isym_sop;
        w_next = w_apply ? TRACK : ACQ;
      end
      default: begin
        // sync loss beats a coincident sop; a sop beats watchdog expiry
        w_wrap = found_sync && isym_sop && (r_sym_idx == IDX_LAST);
        w_apply = w_wrap;
        w_lose = !found_sync || (!isym_sop && r_wdog == WDOG_LAST);
        w_next = w_lose ? FLUSH : TRACK;
      end
    endcase
  end

  assign w_in_rst = (w_next == RST) || (w_next == FLUSH);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RST;
      r_cnt <= '0;
      r_wdog <= '0;
      r_sym_idx <= '0;
      r_cfg <= '0;
      r_shadow <= '0;
      r_pend <= 1'b0;
      r_osof <= 1'b0;
      r_sync_lost <= 1'b0;
      r_dp_rst <= 1'b1;
    end else begin
      r_state <= w_next;
      r_cnt <= (w_next == r_state && w_in_rst) ? r_cnt + 1'b1 : '0;
      r_wdog <= (r_state != TRACK || isym_sop) ? '0 : (r_wdog == WDOG_SAT) ? r_wdog : r_wdog + 1'b1;
      r_sym_idx <= (w_lose || r_state != TRACK) ? '0 : !isym_sop ? r_sym_idx : w_wrap ? '0 : r_sym_idx + 1'b1;
      r_shadow <= cfg_upd ? {index_M, index_SS, index_BW} : r_shadow;
      r_pend <= !w_apply && (r_pend || cfg_upd);
      r_cfg <= !w_apply ? r_cfg : cfg_upd ? {index_M, index_SS, index_BW} : r_pend ? r_shadow : r_cfg;
      r_osof <= w_apply;
      r_sync_lost <= w_lose;
      r_dp_rst <= w_in_rst;
    end
  end

  assign dp_rst = r_dp_rst;
  assign osof = r_osof;
  assign sym_idx = r_sym_idx;
  assign {oindex_M, oindex_SS, oindex_BW} = r_cfg;
  assign locked = (r_state == TRACK);
  assign sync_lost = r_sync_lost;

`ifdef RX_CTRL_STATS_EN
  logic [15:0] r_frame_cnt;
  logic [7:0] r_lost_cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_cnt <= '0;
      r_lost_cnt <= '0;
    end else begin
      r_frame_cnt <= r_frame_cnt + 16'(r_osof);
      r_lost_cnt <= (r_sync_lost && r_lost_cnt != 8'hff) ? r_lost_cnt + 1'b1 : r_lost_cnt;
    end
  end
  assign frame_cnt = r_frame_cnt;
  assign lost_cnt = r_lost_cnt;
`else
  assign frame_cnt = '0;
  assign lost_cnt = '0;
`endif
endmodule

// File: tb/tb_rx_frame_ctrl.sv
// tb_rx_frame_ctrl: scoreboard bench; stimulus queues expected output events, a negedge monitor pops and compares.
module tb_rx_frame_ctrl;
  logic clk = 0, rst = 1, found_sync = 0, isym_sop = 0, cfg_upd = 0;
  logic [2:0] index_M = 0, index_BW = 0;
  logic [3:0] index_SS = 0;
  logic dp_rst, osof, locked, sync_lost;
  logic [6:0] sym_idx;
  logic [2:0] oindex_M, oindex_BW;
  logic [3:0] oindex_SS;
  logic [15:0] frame_cnt;
  logic [7:0] lost_cnt;

  always #5 clk = ~clk;

  rx_frame_ctrl dut (
    .clk(clk), .rst(rst), .found_sync(found_sync), .isym_sop(isym_sop),
    .index_M(index_M), .index_SS(index_SS), .index_BW(index_BW), .cfg_upd(cfg_upd),
    .dp_rst(dp_rst), .osof(osof), .sym_idx(sym_idx), .oindex_M(oindex_M),
    .oindex_SS(oindex_SS), .oindex_BW(oindex_BW), .locked(locked),
    .sync_lost(sync_lost), .frame_cnt(frame_cnt), .lost_cnt(lost_cnt)
  );

  typedef struct packed {
    logic osof, lost;
    logic [6:0] idx;
    logic [2:0] m;
    logic [3:0] ss;
    logic [2:0] bw;
    logic lk;
  } rec_t;

  rec_t q[$];
  rec_t act_r, exp_r;
  int checks = 0, errors = 0, n;
  bit mon_en = 0;
  logic [6:0] prev = 0;
  int e_idx = 0;
  bit e_trk = 0, e_pend = 0;
  logic [2:0] e_m = 0, e_bw = 0, s_m = 0, s_bw = 0;
  logic [3:0] e_ss = 0, s_ss = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic rec_t mk(input bit os, input bit lost, input int idx, input bit lk);
    rec_t r;
    r.osof = os; r.lost = lost; r.idx = 7'(idx);
    r.m = e_m; r.ss = e_ss; r.bw = e_bw; r.lk = lk;
    return r;
  endfunction

  always @(negedge clk) begin
    if (mon_en && (osof || sync_lost || sym_idx !== prev)) begin
      act_r = '{osof, sync_lost, sym_idx, oindex_M, oindex_SS, oindex_BW, locked};
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL event: unexpected output %h", act_r);
      end else begin
        exp_r = q.pop_front();
        if (act_r !== exp_r) begin
          errors++;
          $display("FAIL event: got osof=%b lost=%b idx=%0d cfg=%0d/%0d/%0d lk=%b expected osof=%b lost=%b idx=%0d cfg=%0d/%0d/%0d lk=%b",
            act_r.osof, act_r.lost, act_r.idx, act_r.m, act_r.ss, act_r.bw, act_r.lk,
            exp_r.osof, exp_r.lost, exp_r.idx, exp_r.m, exp_r.ss, exp_r.bw, exp_r.lk);
        end
      end
    end
    prev = sym_idx;
  end

  task automatic do_sop(input bit drop, input bit cu, input logic [2:0] m, input logic [3:0] ss, input logic [2:0] bw);
    bit ap;
    found_sync = !drop; isym_sop = 1; cfg_upd = cu;
    index_M = m; index_SS = ss; index_BW = bw;
    if (drop) begin
      e_idx = 0; e_trk = 0;
      q.push_back(mk(0, 1, 0, 0));
    end else begin
      if (!e_trk) begin
        e_trk = 1; e_idx = 0; ap = 1;
      end else begin
        e_idx = (e_idx == 49) ? 0 : e_idx + 1;
        ap = (e_idx == 0);
      end
      if (ap) begin
        if (cu) {e_m, e_ss, e_bw} = {m, ss, bw};
        else if (e_pend) {e_m, e_ss, e_bw} = {s_m, s_ss, s_bw};
        e_pend = 0;
      end else if (cu) begin
        {s_m, s_ss, s_bw} = {m, ss, bw}; e_pend = 1;
      end
      q.push_back(mk(ap, 0, e_idx, 1));
    end
    tick;
    isym_sop = 0; cfg_upd = 0;
  endtask

  task automatic run(input int cnt, input int gap);
    repeat (cnt) begin
      do_sop(0, 0, 0, 0, 0);
      repeat (gap) tick;
    end
  endtask

  task automatic cfg(input logic [2:0] m, input logic [3:0] ss, input logic [2:0] bw);
    cfg_upd = 1; index_M = m; index_SS = ss; index_BW = bw;
    {s_m, s_ss, s_bw} = {m, ss, bw}; e_pend = 1;
    tick;
    cfg_upd = 0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_dp_rst"}, dp_rst, 1);
    chk({tag, "_osof"}, osof, 0);
    chk({tag, "_sym_idx"}, sym_idx, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_sync_lost"}, sync_lost, 0);
    chk({tag, "_oindex"}, {oindex_M, oindex_SS, oindex_BW}, 0);
  endtask

  task automatic dp_rst_len(input string name);
    n = 0;
    while (dp_rst && n < 100) begin
      n++;
      tick;
    end
    chk(name, n, 16);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    repeat (3) tick;
    chk_reset_vals("reset");
    rst = 0;
    dp_rst_len("dp_rst_after_reset");
    chk("locked_in_acq", locked, 0);
    mon_en = 1;
    found_sync = 1;
    repeat (3) tick;
    do_sop(0, 0, 0, 0, 0);
    chk("locked_after_sop", locked, 1);
    repeat (15) tick;
    run(50, 15);
    run(10, 15);
    cfg(3'd4, 4'd2, 3'd1);
    repeat (14) tick;
    chk("cfg_held_mid_frame", {oindex_M, oindex_SS, oindex_BW}, 0);
    run(39, 15);
    chk("cfg_held_sym49", {oindex_M, oindex_SS, oindex_BW}, 0);
    run(1, 15);
    chk("cfg_applied_wrap", {oindex_M, oindex_SS, oindex_BW}, {3'd4, 4'd2, 3'd1});
    run(5, 15);
    do_sop(1, 0, 0, 0, 0);
    chk("drop_sym_idx", sym_idx, 0);
    dp_rst_len("dp_rst_flush_drop");
    chk("drop_locked", locked, 0);
    found_sync = 1;
    repeat (3) tick;
    do_sop(0, 0, 0, 0, 0);
    repeat (15) tick;
    run(2, 15);
    do_sop(0, 0, 0, 0, 0);
    repeat (2111) tick;
    do_sop(0, 0, 0, 0, 0);
    chk("locked_after_limit_sop", locked, 1);
    repeat (2111) tick;
    do_sop(0, 0, 0, 0, 0);
    q.push_back(mk(0, 1, 0, 0));
    e_idx = 0; e_trk = 0;
    n = 0;
    while (!sync_lost && n < 3000) begin
      tick;
      n++;
    end
    chk("wdog_timeout_clocks", n, 2112);
`ifdef RX_CTRL_STATS_EN
    tick;
    chk("lost_cnt_after_wdog", lost_cnt, 2);
`endif
    repeat (20) tick;
    chk("dp_rst_after_flush", dp_rst, 0);
    chk("locked_after_flush", locked, 0);
    do_sop(0, 0, 0, 0, 0);
    repeat (15) tick;
    run(3, 15);
    cfg(3'd7, 4'd9, 3'd5);
    mon_en = 0;
    rst = 1;
    tick;
    tick;
    chk_reset_vals("midframe_reset");
    {e_m, e_ss, e_bw} = 0; e_pend = 0; e_trk = 0; e_idx = 0;
    rst = 0;
    dp_rst_len("dp_rst_after_reset2");
    mon_en = 1;
    do_sop(0, 0, 0, 0, 0);
    chk("cfg_discarded", {oindex_M, oindex_SS, oindex_BW}, 0);
    repeat (15) tick;
    run(49, 15);
    do_sop(0, 1, 3'd3, 4'd12, 3'd6);
    repeat (5) tick;
    chk("cfg_same_cycle_wrap", {oindex_M, oindex_SS, oindex_BW}, {3'd3, 4'd12, 3'd6});
`ifdef RX_CTRL_STATS_EN
    chk("frame_cnt", frame_cnt, 2);
    chk("lost_cnt_after_reset", lost_cnt, 0);
`else
    chk("frame_cnt_off", frame_cnt, 0);
    chk("lost_cnt_off", lost_cnt, 0);
`endif
    repeat (5) tick;
    chk("scoreboard_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
